// File: rtl/mouse_cursor_tracker.sv
// Turns the PS/2 MouseState word into an absolute, clamped cursor position,
// button levels/press edges and a count of packets lost between samples.
module mouse_cursor_tracker #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COORD_WIDTH = 11,
    parameter int SENS_SHIFT  = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [31:0]            MouseState,
    output logic [COORD_WIDTH-1:0] CursorX,
    output logic [COORD_WIDTH-1:0] CursorY,
    output logic [2:0]             Buttons,
    output logic [2:0]             PressEvt,
    output logic                   Update,
    output logic [15:0]            MissedCount
);

    localparam int EW = COORD_WIDTH + 3;
    localparam logic signed [EW-1:0] MAX_X = EW'(SCREEN_W - 1);
    localparam logic signed [EW-1:0] MAX_Y = EW'(SCREEN_H - 1);

    logic                   armedQ, armedD;
    logic [7:0]             lastSeqQ, lastSeqD;
    logic [15:0]            missedQ, missedD;
    logic                   s1ValidQ, s1ValidD;
    logic [22:0]            s1WordQ, s1WordD;
    logic [COORD_WIDTH-1:0] cursorXQ, cursorXD;
    logic [COORD_WIDTH-1:0] cursorYQ, cursorYD;
    logic [2:0]             buttonsQ, buttonsD;
    logic [2:0]             pressQ, pressD;
    logic                   updateQ, updateD;

    logic [7:0]  seqIn;
    logic [7:0]  seqDiff;
    logic        newPkt;
    logic [16:0] missedSum;
    logic        unusedReserved;

    assign seqIn          = MouseState[31:24];
    assign seqDiff        = seqIn - lastSeqQ;
    assign newPkt         = armedQ && (seqIn != lastSeqQ);
    assign missedSum      = {1'b0, missedQ} + {9'b0, seqDiff} - 17'd1;
    assign unusedReserved = MouseState[23];

    // Stage 1: a changed sequence number is the only trigger; other bits may glitch freely.
    always_comb begin
        armedD   = 1'b1;
        lastSeqD = lastSeqQ;
        missedD  = missedQ;
        s1ValidD = newPkt;
        s1WordD  = s1WordQ;
        if (!armedQ) begin
            lastSeqD = seqIn;
        end else if (newPkt) begin
            lastSeqD = seqIn;
            s1WordD  = MouseState[22:0];
            if (seqDiff > 8'd1) begin
                missedD = missedSum[16] ? 16'hFFFF : missedSum[15:0];
            end
        end
    end

    logic signed [EW-1:0] dxRaw, dyRaw, dxExt, dyExt, nextX, nextY;
    logic [COORD_WIDTH-1:0] clampX, clampY;

    assign dxRaw = {{(EW-9){s1WordQ[8]}}, s1WordQ[8:0]};
    assign dyRaw = {{(EW-9){s1WordQ[17]}}, s1WordQ[17:9]};
    assign dxExt = s1WordQ[21] ? '0 : (dxRaw <<< SENS_SHIFT);
    assign dyExt = s1WordQ[22] ? '0 : (dyRaw <<< SENS_SHIFT);
    assign nextX = $signed({3'b000, cursorXQ}) + dxExt;
    // PS/2 Y is up-positive while screen Y grows downward.
    assign nextY = $signed({3'b000, cursorYQ}) - dyExt;

    always_comb begin
        clampX = nextX[COORD_WIDTH-1:0];
        clampY = nextY[COORD_WIDTH-1:0];
        if (nextX[EW-1])       clampX = '0;
        else if (nextX > MAX_X) clampX = COORD_WIDTH'(SCREEN_W - 1);
        if (nextY[EW-1])       clampY = '0;
        else if (nextY > MAX_Y) clampY = COORD_WIDTH'(SCREEN_H - 1);
    end

    // Stage 2: always builds on the freshly registered cursor so back-to-back packets chain.
    always_comb begin
        cursorXD = cursorXQ;
        cursorYD = cursorYQ;
        buttonsD = buttonsQ;
        pressD   = '0;
        updateD  = 1'b0;
        if (s1ValidQ) begin
            cursorXD = clampX;
            cursorYD = clampY;
            buttonsD = s1WordQ[20:18];
            pressD   = s1WordQ[20:18] & ~buttonsQ;
            updateD  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            armedQ   <= 1'b0;
            lastSeqQ <= '0;
            missedQ  <= '0;
            s1ValidQ <= 1'b0;
            s1WordQ  <= '0;
            cursorXQ <= COORD_WIDTH'(SCREEN_W / 2);
            cursorYQ <= COORD_WIDTH'(SCREEN_H / 2);
            buttonsQ <= '0;
            pressQ   <= '0;
            updateQ  <= 1'b0;
        end else begin
            armedQ   <= armedD;
            lastSeqQ <= lastSeqD;
            missedQ  <= missedD;
            s1ValidQ <= s1ValidD;
            s1WordQ  <= s1WordD;
            cursorXQ <= cursorXD;
            cursorYQ <= cursorYD;
            buttonsQ <= buttonsD;
            pressQ   <= pressD;
            updateQ  <= updateD;
        end
    end

    assign CursorX     = cursorXQ;
    assign CursorY     = cursorYQ;
    assign Buttons     = buttonsQ;
    assign PressEvt    = pressQ;
    assign Update      = updateQ;
    assign MissedCount = missedQ;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: directed and random packets against a packet-level
// model; a second instance runs with SENS_SHIFT=2.
module tb_mouse_cursor_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mouseState;

    logic [10:0] cursorX0, cursorY0, cursorX2, cursorY2;
    logic [2:0]  buttons0, press0, buttons2, press2;
    logic        update0, update2;
    logic [15:0] missed0, missed2;

    always #5 clk = ~clk;

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .COORD_WIDTH(11), .SENS_SHIFT(0)) dut0 (
        .Clk(clk), .Reset(reset), .MouseState(mouseState),
        .CursorX(cursorX0), .CursorY(cursorY0), .Buttons(buttons0), .PressEvt(press0),
        .Update(update0), .MissedCount(missed0)
    );

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .COORD_WIDTH(11), .SENS_SHIFT(2)) dut2 (
        .Clk(clk), .Reset(reset), .MouseState(mouseState),
        .CursorX(cursorX2), .CursorY(cursorY2), .Buttons(buttons2), .PressEvt(press2),
        .Update(update2), .MissedCount(missed2)
    );

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int updSeen    = 0;

    // Packet-level reference: each packet's effect is computed at once and shown two edges later.
    typedef struct {
        int due;
        int x0, y0, x2, y2, btn, press;
    } item_t;
    item_t pend[$];

    int mArmed, mLast, mMissed, lx0, ly0, lx2, ly2, lBtn;
    int vx0, vy0, vx2, vy2, vBtn, vPress, vUpd, vMissed;

    function automatic int clampI(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int s9(logic [8:0] f);
        return f[8] ? int'(f) - 512 : int'(f);
    endfunction

    function automatic logic [31:0] mk(int seq, int dx, int dy, logic [2:0] btn, logic ox, logic oy);
        logic [8:0] fx, fy;
        fx = dx[8:0];
        fy = dy[8:0];
        return {seq[7:0], 1'b0, oy, ox, btn, fy, fx};
    endfunction

    task automatic modelStep(input logic rst, input logic [31:0] w);
        item_t it;
        int seqN, diff, dx, dy, nb;
        if (rst) begin
            pend.delete();
            mArmed = 0; mLast = 0; mMissed = 0;
            lx0 = 320; ly0 = 240; lx2 = 320; ly2 = 240; lBtn = 0;
            vx0 = 320; vy0 = 240; vx2 = 320; vy2 = 240;
            vBtn = 0; vPress = 0; vUpd = 0; vMissed = 0;
        end else begin
            vUpd = 0; vPress = 0;
            if (pend.size() > 0 && pend[0].due == cycle) begin
                it = pend.pop_front();
                vx0 = it.x0; vy0 = it.y0; vx2 = it.x2; vy2 = it.y2;
                vBtn = it.btn; vPress = it.press; vUpd = 1;
            end
            seqN = int'(w[31:24]);
            if (mArmed == 0) begin
                mArmed = 1;
                mLast  = seqN;
            end else if (seqN != mLast) begin
                diff = (seqN - mLast + 256) % 256;
                if (diff > 1) mMissed = (mMissed + diff - 1 > 65535) ? 65535 : mMissed + diff - 1;
                mLast = seqN;
                dx = w[21] ? 0 : s9(w[8:0]);
                dy = w[22] ? 0 : s9(w[17:9]);
                lx0 = clampI(lx0 + dx, 639);
                ly0 = clampI(ly0 - dy, 479);
                lx2 = clampI(lx2 + dx * 4, 639);
                ly2 = clampI(ly2 - dy * 4, 479);
                nb = int'(w[20:18]);
                it.due = cycle + 1;
                it.x0 = lx0; it.y0 = ly0; it.x2 = lx2; it.y2 = ly2;
                it.btn = nb; it.press = nb & ~lBtn;
                lBtn = nb;
                pend.push_back(it);
            end
            vMissed = mMissed;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("cursorX",  32'(cursorX0), vx0);
        chk("cursorY",  32'(cursorY0), vy0);
        chk("buttons",  32'(buttons0), vBtn);
        chk("pressEvt", 32'(press0),   vPress);
        chk("update",   32'(update0),  vUpd);
        chk("missed",   32'(missed0),  vMissed);
        chk("cursorX_s2", 32'(cursorX2), vx2);
        chk("cursorY_s2", 32'(cursorY2), vy2);
        chk("update_s2",  32'(update2),  vUpd);
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] w);
        reset      = rst;
        mouseState = w;
        modelStep(rst, w);
        @(posedge clk);
        #1;
        cycle++;
        if (update0 === 1'b1) updSeen++;
        checkOutput();
    endtask

    task automatic send(input logic [31:0] w);
        applyStimulus(1'b0, w);
        applyStimulus(1'b0, w);
    endtask

    initial begin
        int seq;
        int missedBefore;
        logic [31:0] w;

        $display("[TB] start");
        applyStimulus(1'b1, mk(8'h10, 0, 0, 3'b000, 1'b0, 1'b0));
        applyStimulus(1'b1, mk(8'h10, 0, 0, 3'b000, 1'b0, 1'b0));
        applyStimulus(1'b0, mk(8'h10, 0, 0, 3'b000, 1'b0, 1'b0));
        chk("armNoUpdate", 32'(update0), 0);

        w = mk(8'h11, 5, 3, 3'b000, 1'b0, 1'b0);
        applyStimulus(1'b0, w);
        chk("latencyNotYet", 32'(update0), 0);
        applyStimulus(1'b0, w);
        chk("firstX", 32'(cursorX0), 325);
        chk("firstY", 32'(cursorY0), 237);
        chk("firstUpdate", 32'(update0), 1);
        applyStimulus(1'b0, w);
        chk("updateOnePulse", 32'(update0), 0);

        send(mk(8'h12, -255, -233, 3'b000, 1'b0, 1'b0));
        send(mk(8'h13, -68, 0, 3'b000, 1'b0, 1'b0));
        chk("xAt2", 32'(cursorX0), 2);
        chk("yAt470", 32'(cursorY0), 470);
        send(mk(8'h14, -9, -50, 3'b000, 1'b0, 1'b0));
        chk("clampX0", 32'(cursorX0), 0);
        chk("clampYMax", 32'(cursorY0), 479);

        applyStimulus(1'b1, 32'h0);
        applyStimulus(1'b0, mk(8'h11, 0, 0, 3'b000, 1'b0, 1'b0));
        send(mk(8'h15, 0, 0, 3'b000, 1'b0, 1'b0));
        chk("gapMissed3", 32'(missed0), 3);
        send(mk(8'hFF, 0, 0, 3'b000, 1'b0, 1'b0));
        missedBefore = int'(missed0);
        send(mk(8'h00, 0, 0, 3'b000, 1'b0, 1'b0));
        chk("wrapNoMiss", 32'(missed0), 32'(missedBefore));
        chk("zeroDeltaX", 32'(cursorX0), 320);

        send(mk(8'h01, 0, 0, 3'b001, 1'b0, 1'b0));
        chk("pressL", 32'(press0), 1);
        chk("buttonsL", 32'(buttons0), 1);
        send(mk(8'h02, 0, 0, 3'b001, 1'b0, 1'b0));
        chk("holdL", 32'(press0), 0);

        send(mk(8'h03, 200, 1, 3'b001, 1'b1, 1'b0));
        chk("ovfX", 32'(cursorX0), 320);
        chk("ovfY", 32'(cursorY0), 239);
        send(mk(8'h04, 3, 0, 3'b001, 1'b0, 1'b0));
        chk("sens2X", 32'(cursorX2), 332);
        chk("sens0X", 32'(cursorX0), 323);

        updSeen = 0;
        applyStimulus(1'b0, mk(8'h05, 1, 0, 3'b000, 1'b0, 1'b0));
        applyStimulus(1'b0, mk(8'h06, 1, 0, 3'b000, 1'b0, 1'b0));
        applyStimulus(1'b0, mk(8'h07, 1, 0, 3'b000, 1'b0, 1'b0));
        send(mk(8'h07, 1, 0, 3'b000, 1'b0, 1'b0));
        chk("b2bUpdates", 32'(updSeen), 3);
        chk("b2bX", 32'(cursorX0), 326);

        w = mk(8'h08, 50, 50, 3'b000, 1'b0, 1'b0);
        applyStimulus(1'b0, w);
        applyStimulus(1'b1, w);
        chk("rstStage2Upd", 32'(update0), 0);
        chk("rstStage2X", 32'(cursorX0), 320);
        applyStimulus(1'b0, w);
        applyStimulus(1'b0, w);

        // Random traffic: glitches on an unchanged sequence, gaps, overflows and resets.
        seq = 8;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 63));
            if (r == 0) begin
                applyStimulus(1'b1, $urandom());
            end else begin
                if (r > 20) seq = (seq + ((r > 56) ? int'($urandom_range(2, 6)) : 1)) % 256;
                w = mk(seq, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                       3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
                applyStimulus(1'b0, w);
            end
        end

        applyStimulus(1'b1, 32'h0);
        seq = 0;
        applyStimulus(1'b0, mk(seq, 0, 0, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 262; i++) begin
            seq = (seq + 255) % 256;
            applyStimulus(1'b0, mk(seq, int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                                   3'($urandom_range(0, 7)), 1'b0, 1'b0));
        end
        send(mk((seq + 255) % 256, 0, 0, 3'b000, 1'b0, 1'b0));
        chk("missedSat", 32'(missed0), 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
